// File: rtl/adc_scan_ctrl_if.sv
// Bus bundle between the scan controller and its neighbours: the SPI command
// source, the ADC SPI master and the downstream result consumer.
interface adc_scan_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int CH_W   = 3
);
  logic              cmd_valid_i;
  logic [15:0]       cmd_data_i;
  logic              conv_req_o;
  logic              conv_cal_o;
  logic [CH_W-1:0]   conv_ch_o;
  logic              conv_ack_i;
  logic              conv_done_i;
  logic [DATA_W-1:0] conv_data_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [CH_W-1:0]   res_ch_o;
  logic [DATA_W-1:0] res_data_o;

  // master is the scan controller, slave is everything around it
  modport master (
    input  cmd_valid_i, cmd_data_i, conv_ack_i, conv_done_i, conv_data_i, res_ready_i,
    output conv_req_o, conv_cal_o, conv_ch_o, res_valid_o, res_ch_o, res_data_o
  );

  modport slave (
    output cmd_valid_i, cmd_data_i, conv_ack_i, conv_done_i, conv_data_i, res_ready_i,
    input  conv_req_o, conv_cal_o, conv_ch_o, res_valid_o, res_ch_o, res_data_o
  );
endinterface

// File: rtl/adc_scan_ctrl.sv
// ADC scan controller: decodes configuration commands, runs round-robin channel
// sweeps with optional per-sweep offset calibration, and streams corrected results.
module adc_scan_ctrl #(
  parameter int DATA_W    = 12,
  parameter int CH_W      = 3,
  parameter int SWEEP_GAP = 1000,
  parameter int TIMEOUT   = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  adc_scan_ctrl_if.master bus,
  output logic            adc_en_o,
  output logic            calib_en_o,
  output logic [CH_W-1:0] chan_last_o,
  output logic            busy_o,
  output logic            err_cmd_o,
  output logic            err_tmo_o
);

  localparam int GAP_W = (SWEEP_GAP > 1) ? $clog2(SWEEP_GAP) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SWEEP_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [7:0] OP_EN   = 8'h10;
  localparam logic [7:0] OP_DIS  = 8'h11;
  localparam logic [7:0] OP_CAL  = 8'h12;
  localparam logic [7:0] OP_LAST = 8'h13;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, GAP} state_t;

  // Saturating offset removal: negative differences clamp to zero.
  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] data,
                                                input logic [DATA_W-1:0] offs);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, data}) - $signed({1'b0, offs});
    return (diff < 0) ? '0 : diff[DATA_W-1:0];
  endfunction

  logic [7:0]        opcode;
  logic [7:0]        arg;
  logic              unused_arg_bits;

  logic              adc_en;
  logic              calib_en;
  logic [CH_W-1:0]   chan_last;
  logic              err_cmd;

  state_t            state;
  logic [CH_W-1:0]   sh_last;
  logic              sh_cal;
  logic              cal_phase;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   ch_next;
  logic [DATA_W-1:0] offset;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              conv_req;
  logic              conv_cal;
  logic [CH_W-1:0]   conv_ch;
  logic              res_valid;
  logic [CH_W-1:0]   res_ch;
  logic [DATA_W-1:0] res_data;
  logic              err_tmo;
  logic              sweep_end;
  logic              start_sweep;

  assign opcode          = bus.cmd_data_i[15:8];
  assign arg             = bus.cmd_data_i[7:0];
  assign unused_arg_bits = ^arg[7:CH_W];

  assign ch_next     = ch + CH_W'(1);
  assign sweep_end   = (ch == sh_last) || !adc_en;
  assign start_sweep = adc_en && ((state == IDLE) || ((state == GAP) && (gap_cnt == '0)));

  // Configuration registers: a write is visible one clock after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_en    <= 1'b0;
      calib_en  <= 1'b0;
      chan_last <= '0;
      err_cmd   <= 1'b0;
    end else begin
      err_cmd <= 1'b0;
      if (bus.cmd_valid_i) begin
        unique case (opcode)
          OP_EN:   adc_en    <= 1'b1;
          OP_DIS:  adc_en    <= 1'b0;
          OP_CAL:  calib_en  <= arg[0];
          OP_LAST: chan_last <= arg[CH_W-1:0];
          default: err_cmd   <= 1'b1;
        endcase
      end
    end
  end

  // Sweep sequencer: all bus outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh_last   <= '0;
      sh_cal    <= 1'b0;
      cal_phase <= 1'b0;
      ch        <= '0;
      offset    <= '0;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      conv_req  <= 1'b0;
      conv_cal  <= 1'b0;
      conv_ch   <= '0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_data  <= '0;
      err_tmo   <= 1'b0;
    end else begin
      err_tmo <= 1'b0;
      unique case (state)
        IDLE, GAP: begin
          if (start_sweep) begin
            // Freeze the configuration for the whole sweep.
            sh_last   <= chan_last;
            sh_cal    <= calib_en;
            cal_phase <= calib_en;
            ch        <= '0;
            conv_ch   <= '0;
            conv_cal  <= calib_en;
            conv_req  <= 1'b1;
            state     <= REQ;
          end else if (state == GAP) begin
            if (!adc_en) state <= IDLE;
            else         gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        REQ: begin
          if (bus.conv_ack_i) begin
            conv_req <= 1'b0;
            tmo_cnt  <= '0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (bus.conv_done_i) begin
            if (cal_phase) begin
              offset    <= bus.conv_data_i;
              cal_phase <= 1'b0;
              conv_cal  <= 1'b0;
              conv_ch   <= ch;
              conv_req  <= 1'b1;
              state     <= REQ;
            end else begin
              res_data  <= sh_cal ? sat_sub(bus.conv_data_i, offset) : bus.conv_data_i;
              res_ch    <= ch;
              res_valid <= 1'b1;
              state     <= OUT;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err_tmo <= 1'b1;
            // A lost calibration keeps the old offset and moves on to channel 0.
            if (cal_phase) begin
              cal_phase <= 1'b0;
              conv_cal  <= 1'b0;
              conv_ch   <= ch;
              conv_req  <= 1'b1;
              state     <= REQ;
            end else if (sweep_end) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              ch       <= ch_next;
              conv_ch  <= ch_next;
              conv_req <= 1'b1;
              state    <= REQ;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        OUT: begin
          if (bus.res_ready_i) begin
            res_valid <= 1'b0;
            if (sweep_end) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              ch       <= ch_next;
              conv_ch  <= ch_next;
              conv_req <= 1'b1;
              state    <= REQ;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.conv_req_o  = conv_req;
  assign bus.conv_cal_o  = conv_cal;
  assign bus.conv_ch_o   = conv_ch;
  assign bus.res_valid_o = res_valid;
  assign bus.res_ch_o    = res_ch;
  assign bus.res_data_o  = res_data;

  assign adc_en_o    = adc_en;
  assign calib_en_o  = calib_en;
  assign chan_last_o = chan_last;
  assign busy_o      = (state != IDLE);
  assign err_cmd_o   = err_cmd;
  assign err_tmo_o   = err_tmo;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: command table, directed corner cases and
// randomized sweeps compared against a sweep-level reference model.
module tb_adc_scan_ctrl;
  localparam int DATA_W    = 12;
  localparam int CH_W      = 3;
  localparam int SWEEP_GAP = 20;
  localparam int TIMEOUT   = 64;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } res_t;
  typedef res_t res_q_t[$];

  typedef struct {
    logic [15:0]     cmd;
    logic            en;
    logic            cal;
    logic [CH_W-1:0] last;
    logic            err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic adc_en, calib_en, busy, err_cmd, err_tmo;
  logic [CH_W-1:0] chan_last;

  adc_scan_ctrl_if #(.DATA_W(DATA_W), .CH_W(CH_W)) ifc ();

  adc_scan_ctrl #(
    .DATA_W(DATA_W), .CH_W(CH_W), .SWEEP_GAP(SWEEP_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.master),
    .adc_en_o(adc_en), .calib_en_o(calib_en), .chan_last_o(chan_last),
    .busy_o(busy), .err_cmd_o(err_cmd), .err_tmo_o(err_tmo)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // ADC model controls and observations
  int ack_dly = 2;
  int done_dly = 20;
  int skip_ch = -1;
  bit adc_hold = 1'b0;
  logic [DATA_W-1:0] ch_data [8];
  logic [DATA_W-1:0] cal_data = '0;
  int skip_ack_cyc = 0;
  logic [CH_W-1:0] m_ch;
  logic m_cal;
  logic [CH_W:0] req_log[$];

  bit ready_rand = 1'b0;
  logic ready_val = 1'b1;

  res_t res_q[$];
  int res_cyc_q[$];
  int rise_q[$];
  int tmo_cnt = 0;
  int tmo_cyc = 0;
  logic req_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC SPI master model: ack after ack_dly clocks, done done_dly clocks after ack.
  initial begin
    ifc.conv_ack_i  = 1'b0;
    ifc.conv_done_i = 1'b0;
    ifc.conv_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && ifc.conv_req_o && !adc_hold) begin
        m_ch  = ifc.conv_ch_o;
        m_cal = ifc.conv_cal_o;
        req_log.push_back({m_cal, m_ch});
        for (int i = 1; i < ack_dly; i++) begin @(posedge clk); #1; end
        ifc.conv_ack_i = 1'b1;
        if (!m_cal && int'(m_ch) == skip_ch) skip_ack_cyc = cyc + 1;
        @(posedge clk); #1;
        ifc.conv_ack_i = 1'b0;
        if (m_cal || int'(m_ch) != skip_ch) begin
          for (int i = 1; i < done_dly; i++) begin @(posedge clk); #1; end
          ifc.conv_done_i = 1'b1;
          ifc.conv_data_i = m_cal ? cal_data : ch_data[m_ch];
          @(posedge clk); #1;
          ifc.conv_done_i = 1'b0;
        end
      end
    end
  end

  initial begin
    ifc.res_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      ifc.res_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Observers sample mid-cycle, away from the active edge.
  initial begin
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifc.res_valid_o && ifc.res_ready_i) begin
          res_q.push_back('{ch: ifc.res_ch_o, data: ifc.res_data_o});
          res_cyc_q.push_back(cyc);
        end
        if (ifc.conv_req_o && !req_prev) rise_q.push_back(cyc);
        if (err_tmo) begin
          tmo_cnt++;
          tmo_cyc = cyc;
        end
      end
      req_prev = ifc.conv_req_o;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running, got busy=%0d required finish", busy);
    $fatal(1, "watchdog expired");
  end

  // Reference: one sweep's results from the channel data and calibration rules.
  function automatic res_q_t ref_sweep(input int last, input bit cal, input int skip);
    res_q_t q;
    res_t r;
    int d, o;
    for (int c = 0; c <= last; c++) begin
      if (c != skip) begin
        d = int'(ch_data[c]);
        o = int'(cal_data);
        r.ch   = CH_W'(c);
        r.data = cal ? DATA_W'((d >= o) ? d - o : 0) : DATA_W'(d);
        q.push_back(r);
      end
    end
    return q;
  endfunction

  task automatic send_cmd(input logic [15:0] w);
    @(posedge clk); #1;
    ifc.cmd_valid_i = 1'b1;
    ifc.cmd_data_i  = w;
    @(posedge clk); #1;
    ifc.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_results(input int n, input string name);
    int k;
    k = 0;
    while (res_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (res_q.size() < n) check({name, " result wait"}, res_q.size(), n);
  endtask

  task automatic stop_and_idle(input string name);
    int k;
    send_cmd(16'h1100);
    k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, " idle"}, busy, 1'b0);
  endtask

  task automatic clear_logs();
    res_q.delete();
    res_cyc_q.delete();
    rise_q.delete();
    req_log.delete();
    tmo_cnt = 0;
  endtask

  task automatic compare_results(input res_q_t exp, input string name);
    check({name, " count"}, res_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < res_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), 32'(res_q[i]), 32'(exp[i]));
  endtask

  initial begin
    vec_t vecs[10];
    res_q_t exp, tmp;
    int last, k, stall_bad, gap;
    bit cal;
    res_t snap;
    logic en0, cal0;
    logic [CH_W-1:0] last0;

    vecs[0] = '{16'h1305, 1'b0, 1'b0, 3'd5, 1'b0};
    vecs[1] = '{16'h1201, 1'b0, 1'b1, 3'd5, 1'b0};
    vecs[2] = '{16'h12FE, 1'b0, 1'b0, 3'd5, 1'b0};
    vecs[3] = '{16'h13FA, 1'b0, 1'b0, 3'd2, 1'b0};
    vecs[4] = '{16'h1500, 1'b0, 1'b0, 3'd2, 1'b1};
    vecs[5] = '{16'h0013, 1'b0, 1'b0, 3'd2, 1'b1};
    vecs[6] = '{16'h1203, 1'b0, 1'b1, 3'd2, 1'b0};
    vecs[7] = '{16'h14FF, 1'b0, 1'b1, 3'd2, 1'b1};
    vecs[8] = '{16'h1107, 1'b0, 1'b1, 3'd2, 1'b0};
    vecs[9] = '{16'h1300, 1'b0, 1'b1, 3'd0, 1'b0};

    ifc.cmd_valid_i = 1'b0;
    ifc.cmd_data_i  = '0;
    for (int c = 0; c < 8; c++) ch_data[c] = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst conv_req", ifc.conv_req_o, 1'b0);
    check("rst res_valid", ifc.res_valid_o, 1'b0);
    check("rst adc_en", adc_en, 1'b0);
    check("rst calib_en", calib_en, 1'b0);
    check("rst chan_last", chan_last, '0);
    check("rst busy", busy, 1'b0);
    check("rst errs", {err_cmd, err_tmo}, 2'b00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Command decode table
    for (int i = 0; i < 10; i++) begin
      send_cmd(vecs[i].cmd);
      check($sformatf("cmd%0d adc_en", i), adc_en, vecs[i].en);
      check($sformatf("cmd%0d calib_en", i), calib_en, vecs[i].cal);
      check($sformatf("cmd%0d chan_last", i), chan_last, vecs[i].last);
      check($sformatf("cmd%0d err_cmd", i), err_cmd, vecs[i].err);
    end

    // 8-channel sweep, data = ch*100, gap and repeat
    ack_dly = 2;
    done_dly = 20;
    for (int c = 0; c < 8; c++) ch_data[c] = DATA_W'(c * 100);
    send_cmd(16'h1200);
    send_cmd(16'h1307);
    clear_logs();
    send_cmd(16'h1001);
    wait_results(16, "sweep8");
    stop_and_idle("sweep8");
    exp = ref_sweep(7, 1'b0, -1);
    tmp = ref_sweep(7, 1'b0, -1);
    foreach (tmp[i]) exp.push_back(tmp[i]);
    compare_results(exp, "sweep8");
    gap = (rise_q.size() > 8 && res_cyc_q.size() > 7) ? rise_q[8] - res_cyc_q[7] : -1;
    check("sweep gap", gap, SWEEP_GAP + 1);

    // Calibration: offset 50, data 40/300 -> 0 and 250
    cal_data = 12'd50;
    ch_data[0] = 12'd40;
    ch_data[1] = 12'd300;
    send_cmd(16'h1201);
    send_cmd(16'h1301);
    clear_logs();
    send_cmd(16'h1001);
    wait_results(2, "calib");
    stop_and_idle("calib");
    check("calib req count", req_log.size(), 3);
    check("calib first req", req_log.size() > 0 ? req_log[0] : '0, {1'b1, 3'd0});
    check("calib second req", req_log.size() > 1 ? req_log[1] : '1, {1'b0, 3'd0});
    compare_results(ref_sweep(1, 1'b1, -1), "calib");
    check("calib ch1 value", res_q.size() > 1 ? res_q[1].data : '0, 12'd250);

    // Backpressure: hold ready low for 30 clocks while a result is offered
    send_cmd(16'h1200);
    ch_data[0] = 12'd1234;
    ch_data[1] = 12'd77;
    clear_logs();
    ready_val = 1'b0;
    send_cmd(16'h1001);
    k = 0;
    while (!ifc.res_valid_o && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("stall valid seen", ifc.res_valid_o, 1'b1);
    snap = '{ch: ifc.res_ch_o, data: ifc.res_data_o};
    stall_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!ifc.res_valid_o || ifc.res_ch_o !== snap.ch || ifc.res_data_o !== snap.data ||
          ifc.conv_req_o)
        stall_bad++;
    end
    check("stall stable cycles bad", stall_bad, 0);
    check("stall value", 32'(snap), 32'(res_t'{ch: 3'd0, data: 12'd1234}));
    check("stall no new req", rise_q.size(), 1);
    ready_val = 1'b1;
    wait_results(2, "stall");
    stop_and_idle("stall");
    compare_results(ref_sweep(1, 1'b0, -1), "stall");

    // Timeout on channel 2
    for (int c = 0; c < 8; c++) ch_data[c] = DATA_W'(c * 11 + 5);
    skip_ch = 2;
    send_cmd(16'h1303);
    clear_logs();
    send_cmd(16'h1001);
    wait_results(3, "tmo");
    stop_and_idle("tmo");
    skip_ch = -1;
    compare_results(ref_sweep(3, 1'b0, 2), "tmo");
    check("tmo pulse count", tmo_cnt, 1);
    check("tmo latency", tmo_cyc - skip_ack_cyc, TIMEOUT);
    check("tmo next req", req_log.size() > 3 ? req_log[3] : '0, {1'b0, 3'd3});

    // Disable while channel 3 is converting
    ack_dly = 2;
    done_dly = 20;
    send_cmd(16'h1307);
    clear_logs();
    send_cmd(16'h1001);
    wait_results(3, "disable");
    k = 0;
    while (req_log.size() < 4 && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (ack_dly + 2) @(posedge clk);
    stop_and_idle("disable");
    compare_results(ref_sweep(3, 1'b0, -1), "disable");
    check("disable req count", req_log.size(), 4);

    // chan_last rewritten mid-sweep only shortens the following sweep
    clear_logs();
    send_cmd(16'h1001);
    wait_results(2, "shadow");
    send_cmd(16'h1300);
    wait_results(9, "shadow");
    stop_and_idle("shadow");
    exp = ref_sweep(7, 1'b0, -1);
    tmp = ref_sweep(0, 1'b0, -1);
    foreach (tmp[i]) exp.push_back(tmp[i]);
    compare_results(exp, "shadow");
    check("shadow chan_last", chan_last, 3'd0);

    // Randomized sweeps with random delays and backpressure
    ready_rand = 1'b1;
    for (int it = 0; it < 6; it++) begin
      last = $urandom_range(0, 7);
      cal = 1'($urandom_range(0, 1));
      ack_dly = $urandom_range(1, 3);
      done_dly = $urandom_range(1, 8);
      cal_data = DATA_W'($urandom_range(0, 4095));
      for (int c = 0; c < 8; c++) ch_data[c] = DATA_W'($urandom_range(0, 4095));
      send_cmd({8'h12, 7'd0, cal});
      send_cmd({8'h13, 5'd0, 3'(last)});
      clear_logs();
      send_cmd(16'h1001);
      wait_results(last + 1, $sformatf("rnd%0d", it));
      stop_and_idle($sformatf("rnd%0d", it));
      compare_results(ref_sweep(last, cal, -1), $sformatf("rnd%0d", it));
      check($sformatf("rnd%0d req count", it), req_log.size(), last + 1 + int'(cal));
      check($sformatf("rnd%0d first req", it), req_log.size() > 0 ? req_log[0] : '1,
            {cal, 3'd0});
    end
    ready_rand = 1'b0;
    ready_val = 1'b1;

    // Unknown opcode pulse, then asynchronous reset during REQ
    en0 = adc_en;
    cal0 = calib_en;
    last0 = chan_last;
    send_cmd(16'h1500);
    check("badop pulse", err_cmd, 1'b1);
    check("badop regs", {adc_en, calib_en, chan_last}, {en0, cal0, last0});
    @(posedge clk); #1;
    check("badop pulse width", err_cmd, 1'b0);

    adc_hold = 1'b1;
    send_cmd(16'h1305);
    send_cmd(16'h1001);
    k = 0;
    while (!ifc.conv_req_o && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("pre-reset req", ifc.conv_req_o, 1'b1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async rst conv_req", ifc.conv_req_o, 1'b0);
    check("async rst busy", busy, 1'b0);
    check("async rst regs", {adc_en, calib_en, chan_last}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    adc_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post-reset idle", {busy, ifc.conv_req_o}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
